// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Forwarding select encodings driven onto ForwardAE/ForwardBE.
//   - State encoding of the data-memory wait-state FSM.
//   - Helper that computes an E-stage forwarding select.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M-stage ALU result

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // The M-stage match wins over the W-stage match because it carries the younger value.
  // Register 0 is hardwired to zero and is never forwarded.
  function automatic logic [1:0] fwd_sel_e(input logic [4:0] src,
                                           input logic       reg_write_m,
                                           input logic [4:0] write_reg_m,
                                           input logic       reg_write_w,
                                           input logic [4:0] write_reg_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0 && reg_write_m && src == write_reg_m) begin
      sel = FWD_MEM;
    end else if (src != 5'd0 && reg_write_w && src == write_reg_w) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait-state sequencer for multi-cycle data-memory accesses in the M stage.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous, active-high
//   memop    in  load or store currently in M
//   memstall out pipeline must freeze this cycle
// Each access produces exactly MEM_LATENCY cycles of memstall; the access completes in the
// first following cycle with memstall low. MEM_LATENCY of 0 keeps the FSM in IDLE.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic memop,
  output logic memstall
);

  localparam bit         HasWait = (MEM_LATENCY != 0);
  // The IDLE cycle that accepts the access is the first stall cycle, hence the minus one.
  localparam logic [3:0] CntLoad = HasWait ? 4'(MEM_LATENCY - 1) : 4'd0;

  mem_state_e state_q;
  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memop && HasWait) begin
            state_q <= WAIT;
            cnt_q   <= CntLoad;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    memstall = 1'b0;
    case (state_q)
      IDLE:    memstall = memop & HasWait;
      WAIT:    memstall = (cnt_q != 4'd0);
      default: memstall = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline.
// Drives stall/flush controls for the F/D, D/E, E/M and M/W registers, selects forwarding
// sources for the E-stage ALU and D-stage branch comparator, and counts stalled cycles.
// Ports:
//   clk, reset                      clock (rising edge), asynchronous active-high reset
//   RsD, RtD, RsE, RtE              source registers in D and E
//   WriteRegE/M/W, RegWriteE/M/W    destination register and write enable per stage
//   MemtoRegE, MemtoRegM, MemWriteM load in E, load in M, store in M
//   BranchD, JumpD, PCSrcD          branch/jump decoded in D, branch taken
//   StallF..StallM                  hold PC / pipeline registers
//   FlushD, FlushE, FlushW          bubble into F/D, D/E, M/W
//   ForwardAE/BE, ForwardAD/BD      forwarding selects
//   stall_cycles                    saturating count of cycles with StallF high
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             PCSrcD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [CNT_W-1:0] stall_cycles
);

  logic lw_stall;
  logic branch_stall;
  logic hz_stall;
  logic mem_op;
  logic mem_stall;
  logic run;

  logic [CNT_W-1:0] stall_cnt_q;

  mem_wait_fsm #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_mem_wait_fsm (
    .clk     (clk),
    .reset   (reset),
    .memop   (mem_op),
    .memstall(mem_stall)
  );

  assign mem_op = MemtoRegM | MemWriteM;

  assign lw_stall = MemtoRegE & ((RtE == RsD) | (RtE == RtD));

  assign branch_stall = BranchD &
      ((RegWriteE & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
       (MemtoRegM & ((WriteRegM == RsD) | (WriteRegM == RtD))));

  assign hz_stall = lw_stall | branch_stall;

  // Every control output is held low while reset is asserted.
  assign run = ~reset;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (run) begin
      ForwardAE = fwd_sel_e(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardBE = fwd_sel_e(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardAD = (RsD != 5'd0) & RegWriteM & (RsD == WriteRegM);
      ForwardBD = (RtD != 5'd0) & RegWriteM & (RtD == WriteRegM);
      if (mem_stall) begin
        // Whole pipeline frozen; W is bubbled so the stalled access is not retired twice.
        // No D/E flush here, so a pending load-use is re-evaluated after release only once.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = hz_stall;
        StallD = hz_stall;
        FlushE = hz_stall;
      end
      // A redirect must not discard the instruction being held in D.
      FlushD = (PCSrcD | JumpD) & ~StallD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_LATENCY=2 and a 4-bit stall counter.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM, MemWriteM;
  logic       BranchD, JumpD, PCSrcD;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic [3:0] stall_cycles;

  int n_cmp;
  int n_err;

  logic [12:0] all_out;
  logic [4:0]  mem_grp;

  assign all_out = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                    ForwardAE, ForwardBE, ForwardAD, ForwardBD};
  assign mem_grp = {StallF, StallD, StallE, StallM, FlushW};

  hazard_ctrl #(
    .MEM_LATENCY(2),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .RsD         (RsD),
    .RtD         (RtD),
    .RsE         (RsE),
    .RtE         (RtE),
    .WriteRegE   (WriteRegE),
    .WriteRegM   (WriteRegM),
    .WriteRegW   (WriteRegW),
    .RegWriteE   (RegWriteE),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegE   (MemtoRegE),
    .MemtoRegM   (MemtoRegM),
    .MemWriteM   (MemWriteM),
    .BranchD     (BranchD),
    .JumpD       (JumpD),
    .PCSrcD      (PCSrcD),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .ForwardAD   (ForwardAD),
    .ForwardBD   (ForwardBD),
    .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MemWriteM = 0;
    BranchD = 0; JumpD = 0; PCSrcD = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    // Inputs that would otherwise forward, stall and flush.
    RsE = 5; RtE = 5; WriteRegM = 5; RegWriteM = 1; MemtoRegE = 1; RsD = 5;
    MemtoRegM = 1; JumpD = 1;
    #3;
    check("rst_outs", all_out, 0);
    check("rst_cnt", stall_cycles, 0);
    next_cycle();
    check("rst_hold_outs", all_out, 0);
    clear_inputs();
    reset = 1'b0;

    // RAW forwarding
    next_cycle();
    RsE = 5; RtE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    #1;
    check("fwd_ae_mem", ForwardAE, 2'b10);
    check("fwd_be_mem", ForwardBE, 2'b10);
    check("fwd_no_stall", StallF, 0);
    RegWriteM = 0;
    #1;
    check("fwd_ae_wb", ForwardAE, 2'b01);
    check("fwd_be_wb", ForwardBE, 2'b01);
    RsE = 0;
    #1;
    check("fwd_ae_r0", ForwardAE, 2'b00);
    check("fwd_be_wb2", ForwardBE, 2'b01);
    RegWriteM = 1; RsD = 5;
    #1;
    check("fwd_ad", ForwardAD, 1);
    RsD = 0; WriteRegM = 0;
    #1;
    check("fwd_ad_r0", ForwardAD, 0);

    // Load-use
    next_cycle();
    clear_inputs();
    MemtoRegE = 1; RtE = 8; RsD = 8;
    #1;
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushe", FlushE, 1);
    check("lu_stalle", StallE, 0);
    check("lu_cnt0", stall_cycles, 0);
    next_cycle();
    clear_inputs();
    #1;
    check("lu_release", StallF, 0);
    check("lu_cnt1", stall_cycles, 1);

    // Branch compare hazards
    next_cycle();
    BranchD = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9;
    #1;
    check("br_e_stall", StallF, 1);
    check("br_e_flushe", FlushE, 1);
    next_cycle();
    RegWriteE = 0; WriteRegE = 0; MemtoRegM = 1; WriteRegM = 9;
    #1;
    check("br_m_stall", StallD, 1);
    check("br_cnt2", stall_cycles, 2);
    apply_reset();
    next_cycle();
    BranchD = 1; RtD = 9; RegWriteM = 1; WriteRegM = 9;
    #1;
    check("br_fwd_bd", ForwardBD, 1);
    check("br_fwd_nostall", StallF, 0);

    // Load held in M for MEM_LATENCY=2
    apply_reset();
    next_cycle();
    MemtoRegM = 1;
    #1;
    check("mw_c1", mem_grp, 5'b11111);
    check("mw_c1_flushe", FlushE, 0);
    next_cycle();
    #1;
    check("mw_c2", mem_grp, 5'b11111);
    next_cycle();
    #1;
    check("mw_release", mem_grp, 5'b00000);
    check("mw_cnt", stall_cycles, 2);
    next_cycle();
    MemtoRegM = 0;
    #1;
    check("mw_idle", mem_grp, 5'b00000);
    check("mw_cnt_hold", stall_cycles, 2);

    // Two consecutive stores
    apply_reset();
    next_cycle();
    MemWriteM = 1;
    #1;
    check("st1_c1", mem_grp, 5'b11111);
    next_cycle();
    #1;
    check("st1_c2", mem_grp, 5'b11111);
    next_cycle();
    #1;
    check("st1_release", mem_grp, 5'b00000);
    next_cycle();
    #1;
    check("st2_no_gap", mem_grp, 5'b11111);
    next_cycle();
    #1;
    check("st2_c2", mem_grp, 5'b11111);
    next_cycle();
    #1;
    check("st2_release", mem_grp, 5'b00000);
    next_cycle();
    MemWriteM = 0;
    #1;
    check("st_cnt4", stall_cycles, 4);

    // Jump while load-use stalls D
    apply_reset();
    next_cycle();
    JumpD = 1; MemtoRegE = 1; RtE = 3; RsD = 3;
    #1;
    check("jmp_stall_flushd", FlushD, 0);
    check("jmp_stall_stalld", StallD, 1);
    next_cycle();
    MemtoRegE = 0;
    #1;
    check("jmp_flushd", FlushD, 1);
    check("jmp_stalld", StallD, 0);
    JumpD = 0; PCSrcD = 1;
    #1;
    check("pcsrc_flushd", FlushD, 1);

    // Reset in the first WAIT cycle
    apply_reset();
    next_cycle();
    MemtoRegM = 1;
    #1;
    check("rw_idle_stall", StallM, 1);
    next_cycle();
    #1;
    check("rw_wait1_stall", StallM, 1);
    check("rw_cnt1", stall_cycles, 1);
    reset = 1'b1;
    #1;
    check("rw_rst_outs", all_out, 0);
    check("rw_rst_cnt", stall_cycles, 0);
    next_cycle();
    clear_inputs();
    reset = 1'b0;
    #1;
    check("rw_after_outs", all_out, 0);
    next_cycle();
    #1;
    check("rw_no_residual", all_out, 0);
    check("rw_cnt_after", stall_cycles, 0);

    // Saturation of the 4-bit counter over 20 stalled cycles
    apply_reset();
    next_cycle();
    MemtoRegE = 1; RtE = 8; RsD = 8;
    repeat (19) next_cycle();
    #1;
    check("sat_stall_held", StallF, 1);
    next_cycle();
    clear_inputs();
    #1;
    check("sat_cnt", stall_cycles, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the stall, flush and forwarding-select signals that sequence the F/D, D/E, E/M and M/W pipeline registers. It detects load-use and branch-compare hazards, selects forwarding sources, and runs a wait-state FSM that freezes the pipeline while a multi-cycle data-memory access occupies the M stage. A saturating stall-cycle counter is provided for performance monitoring.

## Interface
Parameters:
- MEM_LATENCY, 2: stall cycles per data-memory access in M. Legal range 0..15; 0 means single-cycle memory and the FSM never leaves IDLE.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- RsD, RtD  in  5  source registers in D
- RsE, RtE  in  5  source registers in E
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  register write enable per stage
- MemtoRegE, MemtoRegM  in  1  load in E / load in M
- MemWriteM  in  1  store in M
- BranchD, JumpD  in  1  branch / jump decoded in D
- PCSrcD  in  1  branch taken (resolved in D)
- StallF, StallD, StallE, StallM  out  1  hold the PC / pipeline register
- FlushD, FlushE, FlushW  out  1  bubble into the F/D, D/E, M/W register
- ForwardAE, ForwardBE  out  2  E-stage ALU operand select
- ForwardAD, ForwardBD  out  1  D-stage comparator operand select
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
- Forwarding:
  - ForwardAE = 2'b10 if RsE≠0 & RegWriteM & RsE==WriteRegM.
  - Otherwise ForwardAE = 2'b01 if RsE≠0 & RegWriteW & RsE==WriteRegW.
  - Otherwise ForwardAE = 2'b00.
  - The M-stage match has priority over the W-stage match.
  - ForwardBE is identical with RtE in place of RsE.
  - ForwardAD = RsD≠0 & RegWriteM & RsD==WriteRegM. ForwardBD is identical with RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & [(RegWriteE & WriteRegE ∈ {RsD,RtD}) | (MemtoRegM & WriteRegM ∈ {RsD,RtD})].
- memop = MemtoRegM | MemWriteM.
- Memory wait FSM, states IDLE and WAIT, with a 4-bit counter cnt:
  - IDLE: if memop & MEM_LATENCY>0, then memstall=1, cnt←MEM_LATENCY-1, next state WAIT. Otherwise memstall=0.
  - WAIT: memstall = (cnt≠0). If cnt≠0, cnt←cnt-1 and stay in WAIT. If cnt==0, go to IDLE; the access completes this cycle.
- Output equations:
  - memstall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0, FlushD=0. Memory stall dominates all other hazards.
  - Otherwise: StallF=StallD=lwstall|branchstall, FlushE=lwstall|branchstall, StallE=StallM=FlushW=0.
  - FlushD = (PCSrcD|JumpD) & ~StallD.
- stall_cycles increments on every cycle in which StallF=1 and saturates at all-ones.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the FSM state, with no added latency.
- Each memory access costs exactly MEM_LATENCY stall cycles. The instruction leaves M on the edge that ends the first cycle with memstall=0.
- Back-to-back memory ops: the second op enters M while the FSM is in IDLE and starts its own wait sequence; there is no idle gap.
- lwstall during memstall: the whole pipeline is frozen, so lwstall is re-evaluated after release. It must not produce a duplicate flush.
- Reset: state=IDLE, cnt=0, stall_cycles=0. While reset is high, every stall, flush and forward output is forced to 0.
- Reset mid-WAIT: the FSM aborts immediately with no residual stall after deassertion.

## Structure
- Shared package hazard_pkg holds:
  - forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - FSM state encoding (IDLE, WAIT)
- One sub-module, mem_wait_fsm: inputs clk, reset, memop; output memstall; parameter MEM_LATENCY.
- Hazard equations and the counter live in the top level.

## Test plan
- RAW forwarding: RsE=RtE=5, WriteRegM=5 with RegWriteM=1, WriteRegW=5 with RegWriteW=1 -> ForwardAE=ForwardBE=2'b10. Drop RegWriteM -> 2'b01. Set RsE=0 -> ForwardAE=2'b00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for 1 cycle. stall_cycles increments by 1.
- Branch hazard: BranchD=1, RegWriteE=1, WriteRegE=RtD=9 -> stall 1 cycle. Then MemtoRegM=1, WriteRegM=9 -> stall a 2nd cycle. Then ForwardBD=1 on RegWriteM=1 match.
- Memory wait, MEM_LATENCY=2: hold a load in M -> StallF..StallM=1 and FlushW=1 for exactly 2 cycles, released in the 3rd. Two consecutive stores -> 4 stall cycles total.
- Jump during stall: JumpD=1 with lwstall=1 -> FlushD=0. Next cycle with lwstall=0 -> FlushD=1.
- Reset mid-WAIT plus saturation:
  - Assert reset in the 1st WAIT cycle -> all outputs 0 immediately, FSM in IDLE, counter 0.
  - Run with CNT_W=4 for 20 stalls -> stall_cycles=4'hF.
